// File: rtl/transpose_ctrl.sv
// transpose_ctrl
//   Tile controller in front of transpose_memory_bank. Input tiles arrive one
//   row per beat and are written diagonally skewed across the NUM_PE banks.
//   Each tile is read back one column per beat and de-skewed, so the output
//   rows are the columns of the input tile (the transpose).
//
//   Optional feature macro: TRANSPOSE_CTRL_PINGPONG_EN
//     defined   : two tile buffers (base addresses 0 and NUM_PE), so tile k+1
//                 can be written while tile k drains.
//     undefined : one tile buffer at base 0; input stalls from the last row of
//                 a tile until that tile's last column read has issued.
//
// Ports
//   clk, rst              clock (rising edge), async active-low reset
//   in_valid/in_ready     input row handshake, in_data[j] = A[r][j]
//   out_valid/out_ready   output row handshake, out_data[i] = A[i][c]
//   out_last              marks the last output row of a tile
//   mem_wen, mem_write_*  bank write port (write on the handshake edge)
//   mem_ren, mem_read_*   bank read port (data returns one cycle after ren)
module transpose_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_PE     = 4,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data        [NUM_PE],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data       [NUM_PE],
  output logic                  out_last,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_write_addr [NUM_PE],
  output logic [DATA_WIDTH-1:0] mem_write_data [NUM_PE],
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_read_addr  [NUM_PE],
  input  logic [DATA_WIDTH-1:0] mem_read_data  [NUM_PE]
);

  localparam int RW = $clog2(NUM_PE);
  localparam logic [RW-1:0] LAST_IDX = RW'(NUM_PE - 1);

`ifdef TRANSPOSE_CTRL_PINGPONG_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif

  logic            wr_buf;
  logic            rd_buf;
  logic [NBUF-1:0] full_q, full_d;
  logic [RW-1:0]   wr_row_q, wr_row_d;
  logic [RW-1:0]   rd_col_q, rd_col_d;
  logic [RW-1:0]   col_q, col_d;
  logic            rd_pend_q, rd_pend_d;
  logic            wr_fire;
  logic            rd_issue;
  logic            wr_wrap;
  logic            rd_wrap;

  assign in_ready  = !full_q[wr_buf];
  assign wr_fire   = in_valid && in_ready;
  // A new column may be read when the pending row is idle or is leaving this
  // cycle; the bank then overwrites its read data on the same edge.
  assign rd_issue  = full_q[rd_buf] && (!rd_pend_q || out_ready);
  assign wr_wrap   = wr_fire && (wr_row_q == LAST_IDX);
  assign rd_wrap   = rd_issue && (rd_col_q == LAST_IDX);

  assign mem_wen   = wr_fire;
  assign mem_ren   = rd_issue;
  assign out_valid = rd_pend_q;
  assign out_last  = rd_pend_q && (col_q == LAST_IDX);

`ifdef TRANSPOSE_CTRL_PINGPONG_EN
  logic wr_buf_q, wr_buf_d;
  logic rd_buf_q, rd_buf_d;

  assign wr_buf = wr_buf_q;
  assign rd_buf = rd_buf_q;

  always_comb begin
    wr_buf_d = wr_buf_q;
    rd_buf_d = rd_buf_q;
    if (wr_wrap) wr_buf_d = ~wr_buf_q;
    if (rd_wrap) rd_buf_d = ~rd_buf_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_buf_q <= 1'b0;
      rd_buf_q <= 1'b0;
    end else begin
      wr_buf_q <= wr_buf_d;
      rd_buf_q <= rd_buf_d;
    end
  end
`else
  assign wr_buf = 1'b0;
  assign rd_buf = 1'b0;
`endif

  // Row r lands at address base+r; element j goes to bank (j+r) mod NUM_PE.
  // Column c is read from bank b at base+((b-c) mod NUM_PE), which puts A[i][c]
  // in bank (c+i) mod NUM_PE; the output mux rotates it back to lane i.
  always_comb begin
    logic [RW-1:0] k;
    k = '0;
    for (int b = 0; b < NUM_PE; b++) begin
      k                 = RW'(b) - wr_row_q;
      mem_write_addr[b] = ADDR_WIDTH'({wr_buf, wr_row_q});
      mem_write_data[b] = in_data[k];
      k                 = RW'(b) - rd_col_q;
      mem_read_addr[b]  = ADDR_WIDTH'({rd_buf, k});
      k                 = col_q + RW'(b);
      out_data[b]       = mem_read_data[k];
    end
  end

  // Set and clear of full always target different buffers when both fire,
  // because a buffer that is full cannot accept the write that would set it.
  always_comb begin
    wr_row_d  = wr_row_q;
    rd_col_d  = rd_col_q;
    col_d     = col_q;
    rd_pend_d = rd_pend_q;
    full_d    = full_q;
    if (wr_fire) wr_row_d = wr_row_q + 1'b1;
    if (wr_wrap) full_d[wr_buf] = 1'b1;
    if (rd_issue) begin
      col_d     = rd_col_q;
      rd_col_d  = rd_col_q + 1'b1;
      rd_pend_d = 1'b1;
    end else if (out_ready) begin
      rd_pend_d = 1'b0;
    end
    if (rd_wrap) full_d[rd_buf] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_row_q  <= '0;
      rd_col_q  <= '0;
      col_q     <= '0;
      rd_pend_q <= 1'b0;
      full_q    <= '0;
    end else begin
      wr_row_q  <= wr_row_d;
      rd_col_q  <= rd_col_d;
      col_q     <= col_d;
      rd_pend_q <= rd_pend_d;
      full_q    <= full_d;
    end
  end

endmodule

// File: tb/tb_transpose_ctrl.sv
// tb_transpose_ctrl
//   Drives transpose_ctrl against a behavioural bank model. The reference
//   keeps every accepted row, and each completed tile pushes its transpose
//   (column c as an output row) onto an expected-row queue.
module tb_transpose_ctrl;

  localparam int DW = 16;
  localparam int NP = 4;
  localparam int AW = 3;
`ifdef TRANSPOSE_CTRL_PINGPONG_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif

  typedef logic [NP-1:0][DW-1:0] row_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data        [NP];
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data       [NP];
  logic          out_last;
  logic          mem_wen;
  logic [AW-1:0] mem_write_addr [NP];
  logic [DW-1:0] mem_write_data [NP];
  logic          mem_ren;
  logic [AW-1:0] mem_read_addr  [NP];
  logic [DW-1:0] mem_read_data  [NP];

  transpose_ctrl #(.DATA_WIDTH(DW), .NUM_PE(NP), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last),
    .mem_wen(mem_wen), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data),
    .mem_ren(mem_ren), .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Bank model: write on the wen edge, read data registered on ren and held.
  logic [DW-1:0] bank [NP][2**AW];
  always @(posedge clk) begin
    for (int b = 0; b < NP; b++) begin
      if (mem_ren) mem_read_data[b] <= bank[b][mem_read_addr[b]];
      if (mem_wen) bank[b][mem_write_addr[b]] <= mem_write_data[b];
    end
  end

  // Reference model state.
  row_t          exp_q[$];
  logic [DW-1:0] tile [NP][NP];
  int            wr_cnt = 0;
  int            out_idx = 0;
  bit            in_fire, out_fire, have_exp;
  row_t          exp_row, got_row;
  logic          exp_last;
  int            n_cmp = 0;
  int            n_fail = 0;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    wr_cnt  = 0;
    out_idx = 0;
  endtask

  task automatic set_row(input int r, input int base);
    for (int j = 0; j < NP; j++) in_data[j] = DW'(base + 16 * r + j + 1);
  endtask

  task automatic set_random();
    for (int j = 0; j < NP; j++) in_data[j] = DW'($urandom);
  endtask

  // Samples the handshakes mid-cycle and advances the reference model.
  task automatic observe();
    row_t r;
    @(negedge clk);
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    for (int i = 0; i < NP; i++) got_row[i] = out_data[i];
    if (in_fire) begin
      for (int j = 0; j < NP; j++) tile[wr_cnt][j] = in_data[j];
      wr_cnt++;
      if (wr_cnt == NP) begin
        for (int c = 0; c < NP; c++) begin
          for (int i = 0; i < NP; i++) r[i] = tile[i][c];
          exp_q.push_back(r);
        end
        wr_cnt = 0;
      end
    end
    have_exp = 1'b0;
    if (out_fire && exp_q.size() > 0) begin
      exp_row  = exp_q.pop_front();
      exp_last = (out_idx == NP - 1);
      have_exp = 1'b1;
      out_idx  = (out_idx + 1) % NP;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, out_last, mem_wen, mem_ren} !== 5'b10000) begin
      n_fail++;
      $display("[TB] FAIL reset_hold: got %b want 10000",
               {in_ready, out_valid, out_last, mem_wen, mem_ren});
    end
    rst = 1'b1;
    observe();
    n_cmp++;
    if ({in_ready, out_valid, out_last, mem_wen, mem_ren} !== 5'b10000) begin
      n_fail++;
      $display("[TB] FAIL reset_release: got %b want 10000",
               {in_ready, out_valid, out_last, mem_wen, mem_ren});
    end
    next_cycle();
  endtask

  task automatic test_single_tile();
    row_t wexp, wgot, aexp, agot;
    int   first, n_out;
    wexp[0] = 16'h14; wexp[1] = 16'h11; wexp[2] = 16'h12; wexp[3] = 16'h13;
    out_ready = 1'b1;
    for (int r = 0; r < NP; r++) begin
      in_valid = 1'b1;
      set_row(r, 0);
      observe();
      n_cmp++;
      if (!in_fire) begin
        n_fail++;
        $display("[TB] FAIL single_accept row %0d: in_ready %b want 1", r, in_ready);
      end
      if (r == 1) begin
        for (int b = 0; b < NP; b++) begin
          wgot[b] = mem_write_data[b];
          agot[b] = DW'(mem_write_addr[b]);
          aexp[b] = DW'(1);
        end
        n_cmp++;
        if (mem_wen !== 1'b1 || wgot !== wexp || agot !== aexp) begin
          n_fail++;
          $display("[TB] FAIL row1_write: wen %b data %h addr %h want 1 %h %h",
                   mem_wen, wgot, agot, wexp, aexp);
        end
      end
      next_cycle();
    end
    in_valid = 1'b0;
    first = -1;
    n_out = 0;
    for (int k = 1; k <= 8; k++) begin
      observe();
      if (k == 1) begin
        for (int b = 0; b < NP; b++) begin
          agot[b] = DW'(mem_read_addr[b]);
          aexp[b] = DW'(b);
        end
        n_cmp++;
        if (mem_ren !== 1'b1 || agot !== aexp) begin
          n_fail++;
          $display("[TB] FAIL col0_read: ren %b addr %h want 1 %h", mem_ren, agot, aexp);
        end
      end
      if (out_valid && first < 0) first = k;
      if (out_fire) begin
        n_out++;
        n_cmp++;
        if (!have_exp || got_row !== exp_row || out_last !== exp_last) begin
          n_fail++;
          $display("[TB] FAIL single_out: got %h last %b want %h last %b",
                   got_row, out_last, exp_row, exp_last);
        end
      end
      next_cycle();
    end
    n_cmp++;
    if (first != 2 || n_out != NP) begin
      n_fail++;
      $display("[TB] FAIL single_latency: first %0d rows %0d want 2 %0d", first, n_out, NP);
    end
  endtask

`ifdef TRANSPOSE_CTRL_PINGPONG_EN
  task automatic test_streaming();
    int first, n_out;
    first = -1;
    n_out = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && n_out < 3 * NP; k++) begin
      in_valid = (k < 3 * NP);
      set_random();
      observe();
      if (k < 3 * NP) begin
        n_cmp++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL stream_in_ready cycle %0d: got %b want 1", k, in_ready);
        end
      end
      if (first >= 0) begin
        n_cmp++;
        if (out_valid !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL stream_gap cycle %0d: out_valid %b want 1", k, out_valid);
        end
      end
      if (out_valid && first < 0) first = k;
      if (out_fire) begin
        n_out++;
        n_cmp++;
        if (!have_exp || got_row !== exp_row || out_last !== exp_last) begin
          n_fail++;
          $display("[TB] FAIL stream_out: got %h last %b want %h last %b",
                   got_row, out_last, exp_row, exp_last);
        end
      end
      next_cycle();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (first != 5 || n_out != 3 * NP) begin
      n_fail++;
      $display("[TB] FAIL stream_count: first %0d rows %0d want 5 %0d", first, n_out, 3 * NP);
    end
  endtask
`else
  task automatic test_single_buffer();
    int   sent, n_out;
    logic want_ready;
    sent = 0;
    n_out = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      in_valid = (sent < 2 * NP);
      set_random();
      observe();
      if (k <= 8) begin
        want_ready = (k < 4) || (k == 8);
        n_cmp++;
        if (in_ready !== want_ready) begin
          n_fail++;
          $display("[TB] FAIL single_buf_ready cycle %0d: got %b want %b", k, in_ready, want_ready);
        end
      end
      if (in_fire) sent++;
      if (out_fire) begin
        n_out++;
        n_cmp++;
        if (!have_exp || got_row !== exp_row || out_last !== exp_last) begin
          n_fail++;
          $display("[TB] FAIL single_buf_out: got %h last %b want %h last %b",
                   got_row, out_last, exp_row, exp_last);
        end
      end
      next_cycle();
      if (sent == 2 * NP && n_out == 2 * NP) break;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (n_out != 2 * NP) begin
      n_fail++;
      $display("[TB] FAIL single_buf_count: rows %0d want %0d", n_out, 2 * NP);
    end
  endtask
`endif

  task automatic test_backpressure();
    row_t hold;
    int   n_out;
    for (int i = 0; i < NP; i++) hold[i] = DW'(16 * i + 2);
    out_ready = 1'b1;
    for (int r = 0; r < NP; r++) begin
      in_valid = 1'b1;
      set_row(r, 0);
      observe();
      next_cycle();
    end
    in_valid = 1'b0;
    n_out = 0;
    for (int k = 1; k <= 14; k++) begin
      out_ready = !(k >= 3 && k <= 5);
      observe();
      if (k >= 3 && k <= 5) begin
        n_cmp++;
        if (out_valid !== 1'b1 || got_row !== hold || mem_ren !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL bp_hold cycle %0d: valid %b data %h ren %b want 1 %h 0",
                   k, out_valid, got_row, mem_ren, hold);
        end
      end
      if (out_fire) begin
        n_out++;
        n_cmp++;
        if (!have_exp || got_row !== exp_row || out_last !== exp_last) begin
          n_fail++;
          $display("[TB] FAIL bp_out: got %h last %b want %h last %b",
                   got_row, out_last, exp_row, exp_last);
        end
      end
      next_cycle();
    end
    n_cmp++;
    if (n_out != NP || exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL bp_count: rows %0d left %0d want %0d 0", n_out, exp_q.size(), NP);
    end
  endtask

  task automatic test_full_stall();
    int sent;
    out_ready = 1'b0;
    for (int r = 0; r < NBUF * NP; r++) begin
      in_valid = 1'b1;
      set_row(r % NP, 256 * (r / NP));
      observe();
      next_cycle();
    end
    set_row(0, 768);
    for (int k = 0; k < 3; k++) begin
      observe();
      n_cmp++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL stall_ready cycle %0d: got %b want 0", k, in_ready);
      end
      next_cycle();
    end
    out_ready = 1'b1;
    sent = 0;
    for (int k = 0; k < 50; k++) begin
      in_valid = (sent < NP);
      set_row(sent, 768);
      observe();
      if (k <= 3) begin
        n_cmp++;
        if (in_ready !== (k == 3)) begin
          n_fail++;
          $display("[TB] FAIL release_ready cycle %0d: got %b want %b", k, in_ready, k == 3);
        end
      end
      if (in_fire) sent++;
      if (out_fire) begin
        n_cmp++;
        if (!have_exp || got_row !== exp_row || out_last !== exp_last) begin
          n_fail++;
          $display("[TB] FAIL stall_out: got %h last %b want %h last %b",
                   got_row, out_last, exp_row, exp_last);
        end
      end
      next_cycle();
      if (sent == NP && exp_q.size() == 0 && !out_valid) break;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (sent != NP || exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL stall_drain: sent %0d left %0d want %0d 0", sent, exp_q.size(), NP);
    end
  endtask

  task automatic test_random();
    bit   stall_prev;
    row_t prev_row;
    logic prev_last;
    stall_prev = 1'b0;
    prev_row   = '0;
    prev_last  = 1'b0;
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      set_random();
      observe();
      if (stall_prev) begin
        n_cmp++;
        if (out_valid !== 1'b1 || got_row !== prev_row || out_last !== prev_last) begin
          n_fail++;
          $display("[TB] FAIL rand_hold cycle %0d: valid %b data %h last %b want 1 %h %b",
                   k, out_valid, got_row, out_last, prev_row, prev_last);
        end
      end
      if (out_fire) begin
        n_cmp++;
        if (!have_exp || got_row !== exp_row || out_last !== exp_last) begin
          n_fail++;
          $display("[TB] FAIL rand_out: got %h last %b want %h last %b",
                   got_row, out_last, exp_row, exp_last);
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_row   = got_row;
      prev_last  = out_last;
      next_cycle();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      in_valid = (wr_cnt != 0);
      set_random();
      observe();
      if (out_fire) begin
        n_cmp++;
        if (!have_exp || got_row !== exp_row || out_last !== exp_last) begin
          n_fail++;
          $display("[TB] FAIL rand_drain_out: got %h last %b want %h last %b",
                   got_row, out_last, exp_row, exp_last);
        end
      end
      next_cycle();
      if (wr_cnt == 0 && exp_q.size() == 0 && !out_valid) break;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0 || wr_cnt != 0) begin
      n_fail++;
      $display("[TB] FAIL rand_drain: left %0d partial %0d want 0 0", exp_q.size(), wr_cnt);
    end
  endtask

  task automatic test_reset_mid_output();
    bit seen;
    out_ready = 1'b1;
    for (int r = 0; r < NP; r++) begin
      in_valid = 1'b1;
      set_row(r, 4096);
      observe();
      next_cycle();
    end
    in_valid = 1'b0;
    repeat (2) begin
      observe();
      next_cycle();
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mid_output_setup: out_valid %b want 1", out_valid);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, out_last, mem_wen, mem_ren} !== 5'b10000) begin
      n_fail++;
      $display("[TB] FAIL mid_reset: got %b want 10000",
               {in_ready, out_valid, out_last, mem_wen, mem_ren});
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      observe();
      if (out_valid) seen = 1'b1;
      next_cycle();
    end
    n_cmp++;
    if (seen || in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL post_reset_idle: saw_valid %b in_ready %b want 0 1", seen, in_ready);
    end
  endtask

  initial begin
    for (int j = 0; j < NP; j++) in_data[j] = '0;
    test_reset();
    test_single_tile();
`ifdef TRANSPOSE_CTRL_PINGPONG_EN
    test_streaming();
`else
    test_single_buffer();
`endif
    test_backpressure();
    test_full_stall();
    test_random();
    test_reset_mid_output();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

endmodule

// File: doc/transpose_ctrl.md
# transpose_ctrl

Ping-pong tile controller sitting directly upstream of `transpose_memory_bank`, and also consuming its read port. Accepts NUM_PE×NUM_PE tiles one row per beat and writes each row diagonally skewed across the NUM_PE banks. Reads each tile back one column per beat, de-skews it and emits the transposed rows. Two tile buffers share the bank address space so that tile k+1 can be written while tile k drains.

## Interface
Parameters:
- DATA_WIDTH, 16, element width
- NUM_PE, 4, banks / elements per beat / tile dimension (power of two)
- ADDR_WIDTH, 3, bank address width; 2^ADDR_WIDTH >= 2*NUM_PE required

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- in_valid  in  1  input row valid
- in_ready  out  1  input row accepted when in_valid && in_ready
- in_data[0:NUM_PE-1]  in  DATA_WIDTH  row r, element j = A[r][j]
- out_valid  out  1  transposed row valid
- out_ready  in  1  downstream accepts
- out_data[0:NUM_PE-1]  out  DATA_WIDTH  output row c, element i = A[i][c]
- out_last  out  1  high with the last output row (c = NUM_PE-1) of a tile
- mem_wen  out  1  to bank wen
- mem_write_addr[0:NUM_PE-1]  out  ADDR_WIDTH  to bank write_addr
- mem_write_data[0:NUM_PE-1]  out  DATA_WIDTH  to bank write_data
- mem_ren  out  1  to bank ren
- mem_read_addr[0:NUM_PE-1]  out  ADDR_WIDTH  to bank read_addr
- mem_read_data[0:NUM_PE-1]  in  DATA_WIDTH  from bank read_data

## Operation
- Bank contract: write on the same edge as mem_wen. mem_read_data is valid one cycle after mem_ren and holds while mem_ren = 0.
- Buffer b uses base address b*NUM_PE.
- State: wr_buf, wr_row (log2 NUM_PE bits), rd_buf, rd_col, full[1:0], rd_pend.
- Write side:
  - in_ready = !full[wr_buf].
  - On accept: mem_wen = 1, every mem_write_addr = base(wr_buf) + wr_row, mem_write_data[b] = in_data[(b − wr_row) mod NUM_PE].
  - wr_row increments. When it wraps from NUM_PE-1 it sets full[wr_buf] and toggles wr_buf.
  - mem_wen is combinational from the handshake; 0 otherwise.
- Read side:
  - Issue condition: full[rd_buf] && (!rd_pend || out_ready).
  - On issue: mem_ren = 1, mem_read_addr[b] = base(rd_buf) + ((b − rd_col) mod NUM_PE). rd_col is registered into col_q, rd_pend is set, and rd_col increments.
  - Issuing column NUM_PE-1 clears full[rd_buf] and toggles rd_buf.
- Output:
  - out_valid = rd_pend.
  - out_data[i] = mem_read_data[(col_q + i) mod NUM_PE].
  - out_last = rd_pend && col_q == NUM_PE-1.
  - rd_pend clears on out_valid && out_ready when no new read issues.
- Simultaneous set/clear of full on different buffers in one cycle: both take effect. The same buffer cannot be set while full.
- All modulo arithmetic wraps in log2(NUM_PE) bits. Address sum never exceeds 2*NUM_PE−1.

## Timing
- Reset (async assert, sync release), all to 0: wr_buf, wr_row, rd_buf, rd_col, col_q, full, rd_pend. Outputs after reset: in_ready=1, out_valid=0, out_last=0, mem_wen=0, mem_ren=0.
- Reset mid-tile discards all buffered data. No partial output follows release.
- Write latency: the row is in the bank at the accept edge.
- Earliest read issue is the cycle after the last row of a tile is accepted.
- First out_valid comes 1 cycle after that issue, so 2 cycles after the last input row.
- With out_ready held at 1: one output row per cycle, NUM_PE rows per tile.
- Ping-pong sustains 1 row/cycle in and out.
- out_data and out_last are stable while out_valid && !out_ready.
- A freed buffer is writable on the cycle after its last read issues.

## Configuration
- TRANSPOSE_CTRL_PINGPONG_EN defined: two buffers as above.
- Not defined:
  - Single buffer. wr_buf and rd_buf are tied to 0, base is always 0, and full is 1 bit.
  - in_ready stays low from the last input row until the last column read has issued.
  - Requirement relaxes to 2^ADDR_WIDTH >= NUM_PE.

## Test plan
Defaults NUM_PE=4, A[r][j] = 16r + j + 1.
- Reset and idle:
  - Hold rst=0 for 2 cycles, then release -> in_ready=1, out_valid=0, mem_wen=0, mem_ren=0.
  - Assert rst mid-output -> same values on the same cycle.
- Single tile:
  - Write rows 0–3 back-to-back.
  - Check the row 1 write -> mem_write_data = {0x14,0x11,0x12,0x13} at address 1.
  - Check the output -> rows {0x01,0x11,0x21,0x31} … {0x04,0x14,0x24,0x34}, with out_last on the 4th and first out_valid 2 cycles after the last input.
- Streaming (PINGPONG_EN): 3 tiles continuous, out_ready=1 -> in_ready never drops and output is 1 row/cycle after the first fill.
- Backpressure: out_ready low for 3 cycles on output row 1 -> out_data holds 0x02,0x12,0x22,0x32, mem_ren=0, and no row is lost or duplicated.
- Full stall: out_ready=0 after 2 tiles written -> in_ready=0; raising out_ready gives in_ready=1 the cycle after buffer 0's last read issues.
- Without PINGPONG_EN: continuous input -> in_ready low from the 4th row accept until the column 3 read issues, and output data is still correct.
